gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_pkg.sv | 33 +++
 rtl/gpio_sync_edge.sv | 41 ++++
 rtl/gpio_bank.sv | 115 +++++++++++
 tb/tb_gpio_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map and edge/status encodings shared by the GPIO bank
package gpio_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] ADDR_DIR     = 4'd0;
  localparam logic [3:0] ADDR_OUT     = 4'd1;
  localparam logic [3:0] ADDR_IN      = 4'd2;
  localparam logic [3:0] ADDR_SET     = 4'd3;
  localparam logic [3:0] ADDR_CLR     = 4'd4;
  localparam logic [3:0] ADDR_TGL     = 4'd5;
  localparam logic [3:0] ADDR_RISE_EN = 4'd6;
  localparam logic [3:0] ADDR_FALL_EN = 4'd7;
  localparam logic [3:0] ADDR_STATUS  = 4'd8;

  // Per-channel edge mode is {FALL_EN[i], RISE_EN[i]}.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic {
    STATUS_IDLE    = 1'b0,
    STATUS_PENDING = 1'b1
  } status_e;

  function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
    return (mode[0] & rise) | (mode[1] & fall);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - one channel: input synchroniser, history flop, registered edge pulses
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_arm,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist <= w_last;
      // Edges are gated until the chain has been refilled from the pads after reset.
      r_rise <= i_arm & w_last & ~r_hist;
      r_fall <= i_arm & ~w_last & r_hist;
    end
  end

  assign o_sync = w_last;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank: direction/output registers, synchronised inputs, edge interrupts
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                cpu_clock,
  input  logic                reset,
  input  logic [3:0]          address,
  input  logic                write_enable,
  input  logic                read_enable,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  input  logic [CHANNELS-1:0] pin_in,
  output logic [CHANNELS-1:0] pin_out,
  output logic [CHANNELS-1:0] pin_config,
  output logic                irq
);

  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

  logic [CHANNELS-1:0] r_dir;
  logic [CHANNELS-1:0] r_out;
  logic [CHANNELS-1:0] r_rise_en;
  logic [CHANNELS-1:0] r_fall_en;
  logic [CHANNELS-1:0] r_status;
  logic [DATA_W-1:0]   r_data_out;
  logic [PRIME_W-1:0]  r_prime;

  logic [CHANNELS-1:0] w_in;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_armed;

  assign w_armed = (r_prime == PRIME_W'(PRIME_CYCLES));
  assign w_wdata = data_in[CHANNELS-1:0];
  assign w_clr   = (write_enable && address == ADDR_STATUS) ? w_wdata : '0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    gpio_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .i_clk  (cpu_clock),
      .i_reset(reset),
      .i_arm  (w_armed),
      .i_pin  (pin_in[g]),
      .o_sync (w_in[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  always_comb begin
    w_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_set[i] = edge_hit(edge_mode_e'({r_fall_en[i], r_rise_en[i]}), w_rise[i], w_fall[i]);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DIR:                     w_rdata[CHANNELS-1:0] = r_dir;
      ADDR_OUT, ADDR_SET,
      ADDR_CLR, ADDR_TGL:           w_rdata[CHANNELS-1:0] = r_out;
      ADDR_IN:                      w_rdata[CHANNELS-1:0] = w_in;
      ADDR_RISE_EN:                 w_rdata[CHANNELS-1:0] = r_rise_en;
      ADDR_FALL_EN:                 w_rdata[CHANNELS-1:0] = r_fall_en;
      ADDR_STATUS:                  w_rdata[CHANNELS-1:0] = r_status;
      default:                      w_rdata = '0;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_dir      <= '0;
      r_out      <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_status   <= '0;
      r_data_out <= '0;
      r_prime    <= '0;
    end else begin
      if (!w_armed) r_prime <= r_prime + 1'b1;
      // A new edge wins over a same-cycle w1c on the same bit.
      r_status <= (r_status & ~w_clr) | w_set;
      if (write_enable) begin
        case (address)
          ADDR_DIR:     r_dir     <= w_wdata;
          ADDR_OUT:     r_out     <= w_wdata;
          ADDR_SET:     r_out     <= r_out | w_wdata;
          ADDR_CLR:     r_out     <= r_out & ~w_wdata;
          ADDR_TGL:     r_out     <= r_out ^ w_wdata;
          ADDR_RISE_EN: r_rise_en <= w_wdata;
          ADDR_FALL_EN: r_fall_en <= w_wdata;
          default:      ;
        endcase
      end else if (read_enable) begin
        r_data_out <= w_rdata;
      end
    end
  end

  assign data_out   = r_data_out;
  assign pin_out    = r_out;
  assign pin_config = r_dir;
  assign irq        = |r_status;

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - self-checking bench for gpio_bank with a sample-history reference model
module tb_gpio_bank;

  localparam int CH = 16;
  localparam int SS = 2;

  logic          cpu_clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    address = '0;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [15:0]   data_in = '0;
  logic [15:0]   data_out;
  logic [CH-1:0] pin_in = '0;
  logic [CH-1:0] pin_out;
  logic [CH-1:0] pin_config;
  logic          irq;

  int total = 0;
  int bad = 0;

  logic [15:0] m_dir, m_out, m_ren, m_fen, m_st, m_dout;
  logic [15:0] m_hist [8];

  gpio_bank #(
    .CHANNELS(CH),
    .SYNC_STAGES(SS)
  ) dut (
    .cpu_clock   (cpu_clock),
    .reset       (reset),
    .address     (address),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .data_in     (data_in),
    .data_out    (data_out),
    .pin_in      (pin_in),
    .pin_out     (pin_out),
    .pin_config  (pin_config),
    .irq         (irq)
  );

  always #5 cpu_clock = ~cpu_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    address = a; data_in = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    address = a; read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  // Reference: registers as plain values, pad samples as a history list (index 0 = newest).
  task automatic model_step(input logic we, input logic re, input logic [3:0] a,
                            input logic [15:0] d, input logic [15:0] p);
    logic [15:0] in_v, cur, prev, set, clr;
    in_v = m_hist[SS-1];
    cur  = m_hist[SS];
    prev = m_hist[SS+1];
    set  = ((cur & ~prev) & m_ren) | ((~cur & prev) & m_fen);
    clr  = (we && a == 4'd8) ? d : 16'h0;
    if (re && !we) begin
      if (a == 4'd0) m_dout = m_dir;
      else if (a == 4'd1 || (a >= 4'd3 && a <= 4'd5)) m_dout = m_out;
      else if (a == 4'd2) m_dout = in_v;
      else if (a == 4'd6) m_dout = m_ren;
      else if (a == 4'd7) m_dout = m_fen;
      else if (a == 4'd8) m_dout = m_st;
      else m_dout = 16'h0;
    end
    if (we) begin
      if (a == 4'd0) m_dir = d;
      else if (a == 4'd1) m_out = d;
      else if (a == 4'd3) m_out = m_out | d;
      else if (a == 4'd4) m_out = m_out & ~d;
      else if (a == 4'd5) m_out = m_out ^ d;
      else if (a == 4'd6) m_ren = d;
      else if (a == 4'd7) m_fen = d;
    end
    m_st = (m_st & ~clr) | set;
    for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = p;
  endtask

  task automatic test_reset();
    reset = 1'b1; pin_in = '0;
    address = 4'd0; data_in = 16'hFFFF; write_enable = 1'b1;
    repeat (3) tick();
    write_enable = 1'b0;
    total++;
    if ({pin_config, pin_out, irq, data_out} !== {16'h0, 16'h0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset_state got cfg=%h out=%h irq=%b dout=%h want all zero", pin_config, pin_out, irq, data_out);
    end
    reset = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_dir_out();
    wr(4'd0, 16'h00FF);
    wr(4'd1, 16'h0F0F);
    total++;
    if (pin_config !== 16'h00FF) begin bad++; $display("FAIL dir_pin_config got=%h want=00ff", pin_config); end
    total++;
    if (pin_out !== 16'h0F0F) begin bad++; $display("FAIL out_pin_out got=%h want=0f0f", pin_out); end
    rd(4'd1);
    total++;
    if (data_out !== 16'h0F0F) begin bad++; $display("FAIL read_out got=%h want=0f0f", data_out); end
    rd(4'd0);
    total++;
    if (data_out !== 16'h00FF) begin bad++; $display("FAIL read_dir got=%h want=00ff", data_out); end
  endtask

  task automatic test_set_clr_tgl();
    wr(4'd1, 16'h0F0F);
    wr(4'd3, 16'hF000);
    wr(4'd4, 16'h000F);
    wr(4'd5, 16'h0101);
    total++;
    if (pin_out !== 16'hFE01) begin bad++; $display("FAIL set_clr_tgl got=%h want=fe01", pin_out); end
    wr(4'd3, 16'h0); wr(4'd4, 16'h0); wr(4'd5, 16'h0);
    total++;
    if (pin_out !== 16'hFE01) begin bad++; $display("FAIL zero_data_ops got=%h want=fe01", pin_out); end
    rd(4'd5);
    total++;
    if (data_out !== 16'hFE01) begin bad++; $display("FAIL read_tgl_alias got=%h want=fe01", data_out); end
    wr(4'd2, 16'hFFFF);
    wr(4'd9, 16'hFFFF);
    rd(4'd9);
    total++;
    if (data_out !== 16'h0) begin bad++; $display("FAIL read_unmapped got=%h want=0000", data_out); end
    rd(4'd1);
    total++;
    if (data_out !== 16'hFE01) begin bad++; $display("FAIL ignored_writes got=%h want=fe01", data_out); end
    address = 4'd0; data_in = 16'h1234; write_enable = 1'b1; read_enable = 1'b1;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    repeat (2) tick();
    total++;
    if ({data_out, pin_config} !== {16'hFE01, 16'h1234}) begin
      bad++; $display("FAIL rw_collision got dout=%h cfg=%h want dout=fe01 cfg=1234", data_out, pin_config);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; address = 4'd1; data_in = 16'hAAAA; write_enable = 1'b1;
    tick();
    reset = 1'b0; write_enable = 1'b0;
    total++;
    if ({pin_out, pin_config, data_out} !== 48'h0) begin
      bad++; $display("FAIL reset_mid got out=%h cfg=%h dout=%h want zero", pin_out, pin_config, data_out);
    end
    repeat (6) tick();
  endtask

  task automatic test_rise();
    logic exp_irq;
    pin_in = '0;
    repeat (6) tick();
    wr(4'd8, 16'hFFFF); wr(4'd7, 16'h0); wr(4'd6, 16'h0001);
    pin_in = 16'h0001;
    for (int k = 1; k <= SS + 2; k++) begin
      tick();
      exp_irq = (k == SS + 2);
      total++;
      if (irq !== exp_irq) begin bad++; $display("FAIL rise_latency cycle=%0d got=%b want=%b", k, irq, exp_irq); end
    end
    rd(4'd8);
    total++;
    if (data_out !== 16'h0001) begin bad++; $display("FAIL rise_status got=%h want=0001", data_out); end
    wr(4'd8, 16'h0001);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b want=0", irq); end
  endtask

  task automatic test_fall();
    pin_in = 16'h0005;
    repeat (6) tick();
    wr(4'd6, 16'h0); wr(4'd7, 16'h0004); wr(4'd8, 16'hFFFF);
    pin_in = 16'h0001;
    repeat (6) tick();
    pin_in = 16'h0005;
    repeat (6) tick();
    rd(4'd8);
    total++;
    if (data_out !== 16'h0004) begin bad++; $display("FAIL fall_status got=%h want=0004", data_out); end
    wr(4'd7, 16'h0);
    rd(4'd8);
    total++;
    if (data_out !== 16'h0004) begin bad++; $display("FAIL enable_off_keeps got=%h want=0004", data_out); end
    wr(4'd8, 16'h0004);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL fall_clear_irq got=%b want=0", irq); end
  endtask

  task automatic test_collision();
    pin_in = '0;
    wr(4'd7, 16'h0); wr(4'd6, 16'h0003);
    repeat (6) tick();
    wr(4'd8, 16'hFFFF);
    pin_in = 16'h0002;
    repeat (6) tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL collision_setup got=%b want=1", irq); end
    pin_in = 16'h0003;
    repeat (SS + 1) tick();
    wr(4'd8, 16'h0003);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL collision_irq got=%b want=1", irq); end
    rd(4'd8);
    total++;
    if (data_out !== 16'h0001) begin bad++; $display("FAIL collision_status got=%h want=0001", data_out); end
    wr(4'd8, 16'hFFFF);
  endtask

  task automatic test_prime();
    pin_in = 16'hFFFF;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    wr(4'd6, 16'hFFFF);
    repeat (10) tick();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL prime_irq got=%b want=0", irq); end
    rd(4'd8);
    total++;
    if (data_out !== 16'h0) begin bad++; $display("FAIL prime_status got=%h want=0000", data_out); end
    pin_in = 16'h7FFF;
    repeat (6) tick();
    pin_in = 16'hFFFF;
    repeat (6) tick();
    rd(4'd8);
    total++;
    if (data_out !== 16'h8000) begin bad++; $display("FAIL post_prime_edge got=%h want=8000", data_out); end
  endtask

  task automatic test_random();
    logic        we, re;
    logic [3:0]  a;
    logic [15:0] d, p;
    reset = 1'b1; pin_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    m_dir = 0; m_out = 0; m_ren = 0; m_fen = 0; m_st = 0; m_dout = 0;
    for (int k = 0; k < 8; k++) m_hist[k] = 16'h0;
    p = 16'h0;
    for (int n = 0; n < 600; n++) begin
      we = (n >= 6) && ($urandom_range(3) == 0);
      re = (n >= 6) && ($urandom_range(2) == 0);
      a  = 4'($urandom_range(15));
      d  = 16'($urandom);
      if (n >= 6 && $urandom_range(2) == 0) p = p ^ (16'h1 << $urandom_range(15));
      write_enable = we; read_enable = re; address = a; data_in = d; pin_in = p;
      tick();
      model_step(we, re, a, d, p);
      total++;
      if ({data_out, pin_out, pin_config, irq} !== {m_dout, m_out, m_dir, (m_st != 16'h0)}) begin
        bad++;
        $display("FAIL random n=%0d got dout=%h out=%h cfg=%h irq=%b want dout=%h out=%h cfg=%h irq=%b",
                 n, data_out, pin_out, pin_config, irq, m_dout, m_out, m_dir, (m_st != 16'h0));
      end
    end
    write_enable = 1'b0; read_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dir_out();
    test_reset_mid();
    test_set_clr_tgl();
    test_rise();
    test_fall();
    test_collision();
    test_prime();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
